// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants.
// Imported by the fetch queue and its neighbours.
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int FETCH_BYTES = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers 8-byte fetch packets
// and issues one instruction per cycle to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [63:0]                fetch_pc_i,
  input  logic [63:0]                fetch_data_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [63:0]                dec_pc_o,
  output logic [INSTR_W-1:0]         dec_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_nx;
  logic [CW-1:0] count;
  logic          half;
  logic          push;
  logic          pop;
  logic          retire;
  fetch_entry_t  head_ent;

  assign fetch_ready_o = (count < FULL);
  assign dec_valid_o   = (count != '0);
  assign count_o       = count;

  assign push    = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop     = dec_valid_o && dec_ready_i;
  assign retire  = pop && half;
  assign head_nx = head + 1'b1;

  assign head_ent = mem[head];

  // Issue side: select the head half, zero when idle.
  always_comb begin
    dec_pc_o    = '0;
    dec_instr_o = '0;
    if (dec_valid_o) begin
      dec_pc_o    = {head_ent.pc[63:3], half, 2'b00};
      dec_instr_o = half ? head_ent.data[63:32]
                         : head_ent.data[31:0];
    end
  end

  // Packet storage; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{pc: fetch_pc_i, data: fetch_data_i};
    end
  end

  // Pointers, occupancy and half pointer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      half  <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (push && !retire) begin
        count <= count + 1'b1;
      end else if (retire && !push) begin
        count <= count - 1'b1;
      end
      if (retire) begin
        head <= head_nx;
        if (count == CW'(1)) begin
          // Next head is the packet landing this cycle, if any.
          half <= push ? fetch_pc_i[2] : 1'b0;
        end else begin
          half <= mem[head_nx].pc[2];
        end
      end else if (pop) begin
        half <= 1'b1;
      end else if (push && count == '0) begin
        half <= fetch_pc_i[2];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for the fetch queue.
// Each scenario task checks its own outputs inline.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [63:0] fetch_pc_i;
  logic [63:0] fetch_data_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [63:0] dec_pc_o;
  logic [31:0] dec_instr_o;
  logic [2:0]  count_o;

  int total;
  int bad;

  fetch_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_data_i  (fetch_data_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pc_o      (dec_pc_o),
    .dec_instr_o   (dec_instr_o),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = '0;
    fetch_data_i  = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    flush_i       = 1'b1;
    fetch_valid_i = 1'b1;
    dec_ready_i   = 1'b1;
    fetch_pc_i    = 64'h1234;
    fetch_data_i  = 64'h5678;
    tick();
    tick();
    total++;
    if (fetch_ready_o !== 1'b1 || dec_valid_o !== 1'b0 ||
        count_o !== 3'd0 || dec_pc_o !== 64'd0 ||
        dec_instr_o !== 32'd0) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b cnt=%0d pc=%h ins=%h want 1 0 0 0 0",
               fetch_ready_o, dec_valid_o, count_o, dec_pc_o, dec_instr_o);
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_full_packet();
    dec_ready_i   = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h8000_0000;
    fetch_data_i  = 64'h2222_2222_1111_1111;
    tick();
    idle_inputs();
    total++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h8000_0000 ||
        dec_instr_o !== 32'h1111_1111) begin
      bad++;
      $display("FAIL full_lo: vld=%b pc=%h ins=%h want 1 80000000 11111111",
               dec_valid_o, dec_pc_o, dec_instr_o);
    end
    tick();
    total++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h8000_0004 ||
        dec_instr_o !== 32'h2222_2222) begin
      bad++;
      $display("FAIL full_hi: vld=%b pc=%h ins=%h want 1 80000004 22222222",
               dec_valid_o, dec_pc_o, dec_instr_o);
    end
    tick();
    total++;
    if (dec_valid_o !== 1'b0 || count_o !== 3'd0 ||
        dec_pc_o !== 64'd0 || dec_instr_o !== 32'd0) begin
      bad++;
      $display("FAIL full_empty: vld=%b cnt=%0d pc=%h ins=%h want 0 0 0 0",
               dec_valid_o, count_o, dec_pc_o, dec_instr_o);
    end
  endtask

  task automatic test_half_packet();
    dec_ready_i   = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h8000_0104;
    fetch_data_i  = 64'hBBBB_BBBB_AAAA_AAAA;
    tick();
    idle_inputs();
    total++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h8000_0104 ||
        dec_instr_o !== 32'hBBBB_BBBB || count_o !== 3'd1) begin
      bad++;
      $display("FAIL half_issue: vld=%b pc=%h ins=%h cnt=%0d want 1 80000104 bbbbbbbb 1",
               dec_valid_o, dec_pc_o, dec_instr_o, count_o);
    end
    tick();
    total++;
    if (dec_valid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL half_done: vld=%b cnt=%0d want 0 0",
               dec_valid_o, count_o);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] base;
    base = 64'h8000_1000;
    dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_valid_i = 1'b1;
      fetch_pc_i    = base + 64'(8 * i);
      fetch_data_i  = {32'hC000_0000 + 32'(2 * i + 1),
                       32'hC000_0000 + 32'(2 * i)};
      tick();
    end
    total++;
    if (count_o !== 3'd4 || fetch_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_full: cnt=%0d rdy=%b want 4 0",
               count_o, fetch_ready_o);
    end
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'hDEAD_0000;
    fetch_data_i  = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    idle_inputs();
    total++;
    if (count_o !== 3'd4) begin
      bad++;
      $display("FAIL bp_fifth: cnt=%0d want 4", count_o);
    end
    dec_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== base + 64'(4 * k) ||
          dec_instr_o !== 32'hC000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL bp_drain%0d: vld=%b pc=%h ins=%h want 1 %h %h",
                 k, dec_valid_o, dec_pc_o, dec_instr_o,
                 base + 64'(4 * k), 32'hC000_0000 + 32'(k));
      end
      tick();
      if (k == 0) begin
        total++;
        if (fetch_ready_o !== 1'b0 || count_o !== 3'd4) begin
          bad++;
          $display("FAIL bp_keep: rdy=%b cnt=%0d want 0 4",
                   fetch_ready_o, count_o);
        end
      end
      if (k == 1) begin
        total++;
        if (fetch_ready_o !== 1'b1 || count_o !== 3'd3) begin
          bad++;
          $display("FAIL bp_retire: rdy=%b cnt=%0d want 1 3",
                   fetch_ready_o, count_o);
        end
      end
    end
    total++;
    if (dec_valid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL bp_empty: vld=%b cnt=%0d want 0 0",
               dec_valid_o, count_o);
    end
  endtask

  task automatic test_flush();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid_i = 1'b1;
      fetch_pc_i    = 64'h8000_2000 + 64'(8 * i);
      fetch_data_i  = 64'h0101_0101_0202_0202;
      tick();
    end
    total++;
    if (count_o !== 3'd3) begin
      bad++;
      $display("FAIL flush_fill: cnt=%0d want 3", count_o);
    end
    flush_i       = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h9000_0000;
    fetch_data_i  = 64'h9999_9999_9999_9999;
    dec_ready_i   = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (count_o !== 3'd0 || dec_valid_o !== 1'b0 ||
        fetch_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL flush: cnt=%0d vld=%b rdy=%b want 0 0 1",
               count_o, dec_valid_o, fetch_ready_o);
    end
    tick();
    total++;
    if (dec_valid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL flush_drop: vld=%b pc=%h want 0",
               dec_valid_o, dec_pc_o);
    end
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'h9000_0100;
    fetch_data_i  = 64'h7777_7777_6666_6666;
    tick();
    idle_inputs();
    total++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 64'h9000_0100 ||
        dec_instr_o !== 32'h6666_6666) begin
      bad++;
      $display("FAIL flush_after: vld=%b pc=%h ins=%h want 1 90000100 66666666",
               dec_valid_o, dec_pc_o, dec_instr_o);
    end
    tick();
    tick();
  endtask

  task automatic test_wrap_stream();
    logic [63:0] exp_pc[$];
    logic [31:0] exp_ins[$];
    int          pkt_left[$];
    int          sent;
    int          cyc;
    int          mcount;
    logic        do_push;
    logic        do_pop;
    logic [63:0] pc;
    sent   = 0;
    cyc    = 0;
    mcount = 0;
    while ((sent < 12 || exp_pc.size() != 0) && cyc < 400) begin
      pc = 64'hA000_0000 + 64'(8 * sent) + ((sent == 0) ? 64'd4 : 64'd0);
      fetch_valid_i = (sent < 12) ? ($urandom_range(0, 3) != 0) : 1'b0;
      fetch_pc_i    = pc;
      fetch_data_i  = {32'hD000_0000 + 32'(2 * sent + 1),
                       32'hD000_0000 + 32'(2 * sent)};
      dec_ready_i   = 1'($urandom_range(0, 1));
      total++;
      if (fetch_ready_o !== (mcount < 4) ||
          dec_valid_o !== (exp_pc.size() != 0) ||
          count_o !== 3'(mcount) || count_o > 3'd4) begin
        bad++;
        $display("FAIL wrap_state c%0d: rdy=%b vld=%b cnt=%0d want cnt %0d",
                 cyc, fetch_ready_o, dec_valid_o, count_o, mcount);
      end
      if (exp_pc.size() != 0) begin
        total++;
        if (dec_pc_o !== exp_pc[0] || dec_instr_o !== exp_ins[0]) begin
          bad++;
          $display("FAIL wrap_issue c%0d: pc=%h ins=%h want %h %h",
                   cyc, dec_pc_o, dec_instr_o, exp_pc[0], exp_ins[0]);
        end
      end
      do_push = fetch_valid_i && (mcount < 4);
      do_pop  = dec_ready_i && (exp_pc.size() != 0);
      if (do_pop) begin
        void'(exp_pc.pop_front());
        void'(exp_ins.pop_front());
        pkt_left[0] = pkt_left[0] - 1;
        if (pkt_left[0] == 0) begin
          void'(pkt_left.pop_front());
          mcount--;
        end
      end
      if (do_push) begin
        if (sent != 0) begin
          exp_pc.push_back({pc[63:3], 3'b000});
          exp_ins.push_back(32'hD000_0000 + 32'(2 * sent));
        end
        exp_pc.push_back({pc[63:3], 3'b100});
        exp_ins.push_back(32'hD000_0000 + 32'(2 * sent + 1));
        pkt_left.push_back((sent == 0) ? 1 : 2);
        mcount++;
        sent++;
      end
      tick();
      cyc++;
    end
    idle_inputs();
    total++;
    if (cyc >= 400 || dec_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap_done: cycles=%0d sent=%0d left=%0d vld=%b want drained",
               cyc, sent, exp_pc.size(), dec_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fetch_valid_i = 1'b1;
      fetch_pc_i    = 64'hB000_0000 + 64'(8 * i);
      fetch_data_i  = 64'h4444_4444_3333_3333;
      tick();
    end
    idle_inputs();
    dec_ready_i = 1'b1;
    tick();
    total++;
    if (dec_pc_o !== 64'hB000_0004 || count_o !== 3'd2) begin
      bad++;
      $display("FAIL mid_pre: pc=%h cnt=%0d want b0000004 2",
               dec_pc_o, count_o);
    end
    rst_n         = 1'b0;
    flush_i       = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_pc_i    = 64'hC000_0000;
    fetch_data_i  = 64'h5555_5555_5555_5555;
    tick();
    total++;
    if (fetch_ready_o !== 1'b1 || dec_valid_o !== 1'b0 ||
        count_o !== 3'd0 || dec_pc_o !== 64'd0 ||
        dec_instr_o !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b vld=%b cnt=%0d pc=%h ins=%h want 1 0 0 0 0",
               fetch_ready_o, dec_valid_o, count_o, dec_pc_o, dec_instr_o);
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n       = 1'b0;
    dec_ready_i = 1'b0;
    test_reset();
    test_full_packet();
    test_half_packet();
    test_backpressure();
    test_flush();
    test_wrap_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting between the L1 instruction cache response path and decode. Accepts 8-byte fetch packets (two 32-bit instructions, addressed by the PC generator's 8-byte-aligned fetch stream or a word-aligned branch target), buffers up to DEPTH packets, and issues one instruction per cycle to decode with its PC. Backpressures fetch when full and discards all buffered state on a branch redirect flush.

## Interface
- DEPTH, 4: packet entries; power of two, ≥2.
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- flush_i  input  1  branch redirect; discard all entries and any same-cycle push.
- fetch_valid_i  input  1  fetch packet present.
- fetch_ready_o  output  1  queue can accept a packet this cycle.
- fetch_pc_i  input  64  packet PC; bit 2 selects starting half, bits [1:0] are ignored (treated as 0).
- fetch_data_i  input  64  [31:0] = instruction at {pc[63:3],3'b000}, [63:32] = instruction at +4.
- dec_valid_o  output  1  instruction available to decode.
- dec_ready_i  input  1  decode accepts the instruction.
- dec_pc_o  output  64  PC of issued instruction.
- dec_instr_o  output  32  issued instruction.
- count_o  output  $clog2(DEPTH+1)  occupied entries.

## Operation
- Push: fetch_valid_i && fetch_ready_o && !flush_i writes {pc, data} at tail; tail increments modulo DEPTH.
- fetch_ready_o = (count < DEPTH); no credit for a same-cycle pop.
- Head entry starts at half = pc[2] (packet at pc[2]=1 holds only the upper instruction valid).
- dec_valid_o = (count != 0). dec_instr_o = head data half selected by half pointer; dec_pc_o = {head_pc[63:3], half, 2'b00}.
- Pop: dec_valid_o && dec_ready_i. If half == 0, half ← 1 (entry retained). If half == 1, entry retired, head increments modulo DEPTH, half ← next head's pc[2] (0 when queue becomes empty).
- Simultaneous push and retire: count unchanged; both pointers move.
- Push into empty queue with concurrent pop impossible (dec_valid_o = 0).
- flush_i: head, tail, count, half ← 0 next cycle; any pop that cycle is still seen by decode but has no further effect; push ignored.
- When dec_valid_o = 0, dec_pc_o and dec_instr_o drive 0.
- Reset (rst_n = 0 at posedge): same effect as flush; rst_n overrides flush_i and all handshakes. Storage contents need not be cleared.

## Timing
- Push-to-issue latency: 1 cycle (no bypass); packet accepted at edge N is on dec_* after edge N.
- Full throughput: one instruction per cycle; a full-width packet drains in 2 cycles, half packet in 1.
- After reset: fetch_ready_o = 1, dec_valid_o = 0, count_o = 0, dec_pc_o = 0, dec_instr_o = 0.
- fetch_ready_o and dec_valid_o are functions of registered state only (no combinational path from any input).
- Flush takes effect at the next edge; first post-flush packet issues one cycle after its push.

## Structure
- fetch_pkg: INSTR_W = 32, FETCH_BYTES = 8, fetch_entry_t struct {logic [63:0] pc; logic [63:0] data;}.
- Single module; storage array of fetch_entry_t, head/tail pointers of $clog2(DEPTH) bits, count register, half bit. No sub-module: the half pointer prevents reuse of a generic FIFO.

## Test plan
- Reset then push pc=0x8000_0000, data=0x2222_2222_1111_1111 with dec_ready_i=1 -> next cycle dec_pc_o=0x8000_0000 instr 0x1111_1111, following cycle 0x8000_0004 instr 0x2222_2222, then dec_valid_o=0.
- Push pc=0x8000_0104 data=0xBBBB_BBBB_AAAA_AAAA -> single issue: pc 0x8000_0104, instr 0xBBBB_BBBB; count_o returns to 0 after one pop.
- dec_ready_i=0, push 4 packets -> count_o=4, fetch_ready_o=0; 5th fetch_valid_i not accepted; release dec_ready_i -> 8 instructions issued in order at consecutive PCs, fetch_ready_o=1 after first retire.
- Fill 3 entries, assert flush_i with concurrent push pc=0x9000_0000 -> next cycle count_o=0, dec_valid_o=0; packet pc=0x9000_0000 is not issued.
- Continuous push and pop past pointer wrap (≥10 packets, dec_ready_i toggled randomly) -> PC sequence strictly +4, no loss or duplication, count_o never exceeds 4.
- Assert rst_n=0 mid-drain with flush_i=1 and fetch_valid_i=1 -> after edge all outputs at reset values.
